// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS main-control FSM:
//   - state_e      : FSM state enumeration
//   - OP_*         : instr[31:26] opcodes understood by the controller
//   - ALUOP_*      : aluop encodings consumed by the ALU decoder
//   - pcw_e        : condition under which the PC is loaded in a state
//   - ctrl_word_t  : per-state control word produced by mc_ctrl_outdec
//   - op_is_legal  : opcode acceptance check used in DECODE
// Optional feature macro: MC_MAINDEC_BNE_EN (makes opcode 000101 legal).
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, IMMEX, IMMWB, BEQEX, BNEEX, JEX
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;
    localparam logic [2:0] ALUOP_LUI   = 3'b101;

    // PC load condition; resolved against mem_ready/zero in the top.
    typedef enum logic [2:0] {
        PCW_NEVER, PCW_READY, PCW_ZERO, PCW_NZERO, PCW_ALWAYS
    } pcw_e;

    // memwrite/irwrite are raw "this state writes" flags, still to be
    // qualified by mem_ready in the top.
    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        pcw_e       pcw;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal_op;
    } ctrl_word_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI,
            OP_SLTI, OP_ORI, OP_LUI, OP_J:            ok = 1'b1;
`ifdef MC_MAINDEC_BNE_EN
            OP_BNE:                                   ok = 1'b1;
`endif
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_maindec_if.sv
// ---------------------------------------------------------------------------
// mc_maindec_if
// Bundle between the main-control FSM and the datapath/memory.
//   op, zero, mem_ready          : datapath -> controller
//   memwrite .. illegal_op       : controller -> datapath
// Modports: master = controller (mc_maindec), slave = datapath side.
// ---------------------------------------------------------------------------
interface mc_maindec_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output memwrite, irwrite, regwrite, pcwrite, alusrca, alusrcb,
               zeroext, iord, memtoreg, regdst, pcsrc, aluop, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  memwrite, irwrite, regwrite, pcwrite, alusrca, alusrcb,
               zeroext, iord, memtoreg, regdst, pcsrc, aluop, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// ---------------------------------------------------------------------------
// mc_ctrl_outdec
// Purely combinational Moore output decode: (state, op) -> ctrl_word_t.
// op is only consulted in DECODE (illegal detection) and in IMMEX/IMMWB
// (per-instruction aluop/zeroext); the IR holds it stable there.
// Ports:
//   state_i  in   state_e      current (reset-overridden) FSM state
//   op_i     in   6            instr[31:26]
//   ctrl_o   out  ctrl_word_t  raw control word (strobes not yet gated)
// Optional feature macro: MC_MAINDEC_BNE_EN (enables the BNEEX decode).
// ---------------------------------------------------------------------------
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        // NOTE: default every field up front so no path through the case
        // leaves a bit unassigned, which would infer a latch.
        ctrl_o     = '0;
        ctrl_o.pcw = PCW_NEVER;
        case (state_i)
            FETCH: begin
                ctrl_o.irwrite = 1'b1;
                ctrl_o.pcw     = PCW_READY;
                ctrl_o.alusrcb = 2'b01;
            end
            DECODE: begin
                ctrl_o.alusrcb    = 2'b11;
                ctrl_o.illegal_op = !op_is_legal(op_i);
            end
            MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b10;
            end
            MEMRD:  ctrl_o.iord = 1'b1;
            MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_RTYPE;
            end
            RTYPEWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            IMMEX, IMMWB: begin
                // aluop/zeroext stay valid through writeback so the ALU
                // result on the writeback path does not change.
                case (op_i)
                    OP_SLTI: ctrl_o.aluop = ALUOP_SLT;
                    OP_ORI:  ctrl_o.aluop = ALUOP_OR;
                    OP_LUI:  ctrl_o.aluop = ALUOP_LUI;
                    default: ctrl_o.aluop = ALUOP_ADD;
                endcase
                ctrl_o.zeroext = (op_i == OP_ORI);
                if (state_i == IMMEX) begin
                    ctrl_o.alusrca = 1'b1;
                    ctrl_o.alusrcb = 2'b10;
                end else begin
                    ctrl_o.regwrite = 1'b1;
                end
            end
            BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = 2'b01;
                ctrl_o.pcw     = PCW_ZERO;
            end
`ifdef MC_MAINDEC_BNE_EN
            BNEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = 2'b01;
                ctrl_o.pcw     = PCW_NZERO;
            end
`endif
            JEX: begin
                ctrl_o.pcsrc = 2'b10;
                ctrl_o.pcw   = PCW_ALWAYS;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// ---------------------------------------------------------------------------
// mc_maindec
// Multicycle MIPS main-control FSM (Moore). Sequences fetch/decode/execute/
// mem/writeback and drives datapath enables, mux selects and aluop for the
// downstream ALU decoder. Memory is single-ported with a mem_ready handshake.
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous, active-high
//   bus    mc_maindec_if.master
//          in : op[5:0], zero, mem_ready
//          out: memwrite, irwrite, regwrite, pcwrite, alusrca, alusrcb[1:0],
//               zeroext, iord, memtoreg, regdst, pcsrc[1:0], aluop[2:0],
//               illegal_op
// Optional feature macro: MC_MAINDEC_BNE_EN (adds bne via BNEEX).
// ---------------------------------------------------------------------------
module mc_maindec
    import mc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mc_maindec_if.master  bus
);

    state_e     state_q, state_d;
    state_e     dec_state;
    ctrl_word_t cw;
    logic       pc_en;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:                     state_d = MEMADR;
                    OP_RTYPE:                         state_d = RTYPEEX;
                    OP_BEQ:                           state_d = BEQEX;
                    OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state_d = IMMEX;
                    OP_J:                             state_d = JEX;
`ifdef MC_MAINDEC_BNE_EN
                    OP_BNE:                           state_d = BNEEX;
`endif
                    default:                          state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (bus.mem_ready) state_d = MEMWB;
            MEMWR:   if (bus.mem_ready) state_d = FETCH;
            RTYPEEX: state_d = RTYPEWB;
            IMMEX:   state_d = IMMWB;
            default: state_d = FETCH;
        endcase
    end

    // During reset the selects show FETCH values regardless of the stale
    // state register, and all strobes are suppressed below.
    assign dec_state = reset ? FETCH : state_q;

    mc_ctrl_outdec u_outdec (
        .state_i (dec_state),
        .op_i    (bus.op),
        .ctrl_o  (cw)
    );

    always_comb begin
        case (cw.pcw)
            PCW_READY:  pc_en = bus.mem_ready;
            PCW_ZERO:   pc_en = bus.zero;
            PCW_NZERO:  pc_en = !bus.zero;
            PCW_ALWAYS: pc_en = 1'b1;
            default:    pc_en = 1'b0;
        endcase
    end

    assign bus.memwrite   = !reset && cw.memwrite && bus.mem_ready;
    assign bus.irwrite    = !reset && cw.irwrite  && bus.mem_ready;
    assign bus.regwrite   = !reset && cw.regwrite;
    assign bus.pcwrite    = !reset && pc_en;
    assign bus.illegal_op = !reset && cw.illegal_op;
    assign bus.alusrca    = cw.alusrca;
    assign bus.alusrcb    = cw.alusrcb;
    assign bus.zeroext    = cw.zeroext;
    assign bus.iord       = cw.iord;
    assign bus.memtoreg   = cw.memtoreg;
    assign bus.regdst     = cw.regdst;
    assign bus.pcsrc      = cw.pcsrc;
    assign bus.aluop      = cw.aluop;

endmodule

// File: tb/tb_mc_maindec.sv
// ---------------------------------------------------------------------------
// tb_mc_maindec
// Builds, per instruction, the expected per-cycle control outputs from the
// instruction-level rules (phase list, wait cycles, branch condition) and
// compares them against mc_maindec. Honours MC_MAINDEC_BNE_EN.
// ---------------------------------------------------------------------------
module tb_mc_maindec;

    localparam logic [5:0] R_OP = 6'b000000, J_OP = 6'b000010, BEQ_OP = 6'b000100;
    localparam logic [5:0] BNE_OP = 6'b000101, ADDI_OP = 6'b001000, SLTI_OP = 6'b001010;
    localparam logic [5:0] ORI_OP = 6'b001101, LUI_OP = 6'b001111, LW_OP = 6'b100011;
    localparam logic [5:0] SW_OP = 6'b101011, BAD_OP = 6'b111111;

    typedef struct packed {
        logic       memwrite, irwrite, regwrite, pcwrite, alusrca;
        logic [1:0] alusrcb;
        logic       zeroext, iord, memtoreg, regdst;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       z;
        logic [5:0] op;
        outs_t      exp;
    } step_t;

    logic  clk;
    logic  reset;
    outs_t obs;
    step_t q[$];
    int    n_cmp;
    int    n_err;

    mc_maindec_if bus ();

    mc_maindec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit legal(input logic [5:0] op);
        bit ok;
        ok = op inside {LW_OP, SW_OP, R_OP, BEQ_OP, ADDI_OP, SLTI_OP, ORI_OP, LUI_OP, J_OP};
`ifdef MC_MAINDEC_BNE_EN
        if (op == BNE_OP) ok = 1'b1;
`endif
        return ok;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Output seen in FETCH with no strobes; also the required reset view.
    function automatic outs_t fetch_idle();
        outs_t o;
        o = '0;
        o.alusrcb = 2'b01;
        return o;
    endfunction

    task automatic push(input logic rst, input logic rdy, input logic z,
                        input logic [5:0] op, input outs_t exp);
        step_t s;
        s.rst = rst; s.rdy = rdy; s.z = z; s.op = op; s.exp = exp;
        q.push_back(s);
    endtask

    // Expected cycles of one instruction: fw FETCH waits, mw memory waits.
    task automatic plan(input logic [5:0] op, input logic z, input int fw, input int mw);
        outs_t o;
        logic [2:0] imm_aluop;
        for (int i = 0; i < fw; i++) push(1'b0, 1'b0, rb(), op, fetch_idle());
        o = fetch_idle(); o.irwrite = 1'b1; o.pcwrite = 1'b1;
        push(1'b0, 1'b1, rb(), op, o);
        o = '0; o.alusrcb = 2'b11; o.illegal_op = !legal(op);
        push(1'b0, rb(), rb(), op, o);
        if (!legal(op)) return;
        case (op)
            LW_OP, SW_OP: begin
                o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
                push(1'b0, rb(), rb(), op, o);
                o = '0; o.iord = 1'b1;
                for (int i = 0; i < mw; i++) push(1'b0, 1'b0, rb(), op, o);
                o.memwrite = (op == SW_OP);
                push(1'b0, 1'b1, rb(), op, o);
                if (op == LW_OP) begin
                    o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1;
                    push(1'b0, rb(), rb(), op, o);
                end
            end
            R_OP: begin
                o = '0; o.alusrca = 1'b1; o.aluop = 3'b100;
                push(1'b0, rb(), rb(), op, o);
                o = '0; o.regdst = 1'b1; o.regwrite = 1'b1;
                push(1'b0, rb(), rb(), op, o);
            end
            ADDI_OP, SLTI_OP, ORI_OP, LUI_OP: begin
                imm_aluop = (op == ADDI_OP) ? 3'b000 : (op == SLTI_OP) ? 3'b010 :
                            (op == ORI_OP)  ? 3'b011 : 3'b101;
                o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
                o.aluop = imm_aluop; o.zeroext = (op == ORI_OP);
                push(1'b0, rb(), rb(), op, o);
                o = '0; o.regwrite = 1'b1; o.aluop = imm_aluop; o.zeroext = (op == ORI_OP);
                push(1'b0, rb(), rb(), op, o);
            end
            BEQ_OP, BNE_OP: begin
                o = '0; o.alusrca = 1'b1; o.aluop = 3'b001; o.pcsrc = 2'b01;
                o.pcwrite = (op == BEQ_OP) ? z : !z;
                push(1'b0, rb(), z, op, o);
            end
            J_OP: begin
                o = '0; o.pcsrc = 2'b10; o.pcwrite = 1'b1;
                push(1'b0, rb(), rb(), op, o);
            end
            default: ;
        endcase
    endtask

    task automatic apply(input step_t s);
        @(negedge clk);
        reset         = s.rst;
        bus.mem_ready = s.rdy;
        bus.zero      = s.z;
        bus.op        = s.op;
        #1;
        obs = {bus.memwrite, bus.irwrite, bus.regwrite, bus.pcwrite, bus.alusrca,
               bus.alusrcb, bus.zeroext, bus.iord, bus.memtoreg, bus.regdst,
               bus.pcsrc, bus.aluop, bus.illegal_op};
    endtask

    task automatic test_reset();
        push(1'b1, 1'b1, 1'b0, LW_OP, fetch_idle());
        push(1'b1, 1'b1, 1'b0, LW_OP, fetch_idle());
        plan(LW_OP, 1'b0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL reset_lw step %0d: got %b want %b", i, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_sw_wait();
        plan(SW_OP, 1'b0, 0, 3);
        plan(J_OP, 1'b0, 1, 0);
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL sw_wait step %0d: got %b want %b", i, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_rtype_imm();
        plan(R_OP, 1'b0, 0, 0);
        plan(ORI_OP, 1'b0, 0, 0);
        plan(LUI_OP, 1'b0, 1, 0);
        plan(SLTI_OP, 1'b0, 0, 0);
        plan(ADDI_OP, 1'b0, 2, 0);
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL rtype_imm step %0d: got %b want %b", i, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_branch();
        plan(BEQ_OP, 1'b1, 0, 0);
        plan(BEQ_OP, 1'b0, 0, 0);
        plan(BNE_OP, 1'b0, 0, 0);
        plan(BNE_OP, 1'b1, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL branch step %0d: got %b want %b", i, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_illegal();
        plan(BAD_OP, 1'b0, 0, 0);
        plan(R_OP, 1'b0, 0, 0);
        plan(BAD_OP, 1'b1, 1, 0);
        plan(J_OP, 1'b0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL illegal step %0d: got %b want %b", i, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    // Reset lands while the FSM sits in a writing state: no write may occur
    // and the next instruction starts from FETCH.
    task automatic test_reset_mid();
        plan(LW_OP, 1'b0, 0, 0);
        while (q.size() > 4) void'(q.pop_back());
        push(1'b1, 1'b1, 1'b1, LW_OP, fetch_idle());
        plan(SW_OP, 1'b0, 0, 0);
        while (q.size() > 8) void'(q.pop_back());
        push(1'b1, 1'b1, 1'b1, SW_OP, fetch_idle());
        plan(J_OP, 1'b0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL reset_mid step %0d: got %b want %b", i, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_random();
        logic [5:0] pool [12];
        logic [5:0] op;
        pool = '{LW_OP, SW_OP, R_OP, BEQ_OP, BNE_OP, ADDI_OP, SLTI_OP,
                 ORI_OP, LUI_OP, J_OP, BAD_OP, 6'b110000};
        for (int k = 0; k < 60; k++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                             : pool[$urandom_range(0, 11)];
            plan(op, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL random step %0d op %b: got %b want %b",
                         i, q[i].op, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.op        = 6'b000000;
        test_reset();
        test_sw_wait();
        test_rtype_imm();
        test_branch();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
